// File: rtl/mm_round_ctrl.sv
// mm_round_ctrl: Mastermind round controller.
// Sequences secret-code entry, guess entry, per-peg comparison and
// end-of-game detection from a single debounced load button.
// Optional build macro: MM_RESTART_EN. When it is defined, a press and
// release in WON or LOST starts a new game. When it is undefined, the
// end states are terminal until resetn is asserted.
module mm_round_ctrl #(
   parameter int N_PEGS      = 4,
   parameter int IDX_W       = 2,
   parameter int MAX_GUESSES = 10,
   parameter int CNT_W       = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              load,
   input  logic              all_exact,
   output logic [N_PEGS-1:0] load_code,
   output logic [N_PEGS-1:0] load_guess,
   output logic              compare,
   output logic [IDX_W-1:0]  compare_i,
   output logic              result_done,
   output logic [CNT_W-1:0]  guess_count,
   output logic              game_won,
   output logic              game_over
);

   typedef enum logic [3:0] {
      S_LOAD_CODE      = 4'd0,
      S_LOAD_CODE_WAIT = 4'd1,
      S_GUESS          = 4'd2,
      S_GUESS_WAIT     = 4'd3,
      S_COMPARE        = 4'd4,
      S_RESULT_DONE    = 4'd5,
      S_WON            = 4'd6,
      S_LOST           = 4'd7,
      S_WON_WAIT       = 4'd8,
      S_LOST_WAIT      = 4'd9
   } state_t;

   localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(N_PEGS - 1);
   localparam logic [IDX_W-1:0]  SLOT_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]  SLOT_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_GUESSES);
   localparam logic [N_PEGS-1:0] PEG_ZERO  = {N_PEGS{1'b0}};
   localparam logic [N_PEGS-1:0] PEG_ONE   = {{(N_PEGS-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   slot_q, slot_d;
   logic [CNT_W-1:0]   guess_count_q, guess_count_d;
   logic [CNT_W-1:0]   guess_inc;

   logic [N_PEGS-1:0]  load_code_q, load_code_d;
   logic [N_PEGS-1:0]  load_guess_q, load_guess_d;
   logic               compare_q, compare_d;
   logic [IDX_W-1:0]   compare_i_q, compare_i_d;
   logic               result_done_q, result_done_d;
   logic               game_won_q, game_won_d;
   logic               game_over_q, game_over_d;

   // Saturating increment of the guess counter; it can never wrap past MAX_GUESSES.
   always_comb begin
      if (guess_count_q < MAX_CNT) begin
         guess_inc = guess_count_q + CNT_ONE;
      end else begin
         guess_inc = guess_count_q;
      end
   end

   // Next-state logic: press moves to a WAIT state, release advances one slot.
   always_comb begin
      state_d       = state_q;
      slot_d        = slot_q;
      guess_count_d = guess_count_q;
      case (state_q)
         S_LOAD_CODE: begin
            if (load) begin
               state_d = S_LOAD_CODE_WAIT;
            end else begin
               state_d = S_LOAD_CODE;
            end
         end
         S_LOAD_CODE_WAIT: begin
            if (load) begin
               state_d = S_LOAD_CODE_WAIT;
            end else if (slot_q == LAST_SLOT) begin
               state_d = S_GUESS;
               slot_d  = SLOT_ZERO;
            end else begin
               state_d = S_LOAD_CODE;
               slot_d  = slot_q + SLOT_ONE;
            end
         end
         S_GUESS: begin
            if (load) begin
               state_d = S_GUESS_WAIT;
            end else begin
               state_d = S_GUESS;
            end
         end
         S_GUESS_WAIT: begin
            if (load) begin
               state_d = S_GUESS_WAIT;
            end else if (slot_q == LAST_SLOT) begin
               state_d = S_COMPARE;
               slot_d  = SLOT_ZERO;
            end else begin
               state_d = S_GUESS;
               slot_d  = slot_q + SLOT_ONE;
            end
         end
         S_COMPARE: begin
            if (slot_q == LAST_SLOT) begin
               state_d = S_RESULT_DONE;
               slot_d  = SLOT_ZERO;
            end else begin
               state_d = S_COMPARE;
               slot_d  = slot_q + SLOT_ONE;
            end
         end
         S_RESULT_DONE: begin
            slot_d        = SLOT_ZERO;
            guess_count_d = guess_inc;
            if (all_exact) begin
               state_d = S_WON;
            end else if (guess_inc == MAX_CNT) begin
               state_d = S_LOST;
            end else begin
               state_d = S_GUESS;
            end
         end
`ifdef MM_RESTART_EN
         S_WON: begin
            if (load) begin
               state_d = S_WON_WAIT;
            end else begin
               state_d = S_WON;
            end
         end
         S_LOST: begin
            if (load) begin
               state_d = S_LOST_WAIT;
            end else begin
               state_d = S_LOST;
            end
         end
         S_WON_WAIT, S_LOST_WAIT: begin
            if (load) begin
               state_d = state_q;
            end else begin
               state_d       = S_LOAD_CODE;
               slot_d        = SLOT_ZERO;
               guess_count_d = CNT_ZERO;
            end
         end
`else
         S_WON: begin
            state_d = S_WON;
         end
         S_LOST: begin
            state_d = S_LOST;
         end
`endif
         default: begin
            state_d = S_LOAD_CODE;
            slot_d  = SLOT_ZERO;
         end
      endcase
   end

   // Output decode from the next state so that every output leaves a flop.
   always_comb begin
      load_code_d   = PEG_ZERO;
      load_guess_d  = PEG_ZERO;
      compare_d     = 1'b0;
      compare_i_d   = SLOT_ZERO;
      result_done_d = 1'b0;
      game_won_d    = 1'b0;
      game_over_d   = 1'b0;
      case (state_d)
         S_LOAD_CODE: begin
            load_code_d = PEG_ONE << slot_d;
         end
         S_GUESS: begin
            load_guess_d = PEG_ONE << slot_d;
         end
         S_COMPARE: begin
            compare_d   = 1'b1;
            compare_i_d = slot_d;
         end
         S_RESULT_DONE: begin
            result_done_d = 1'b1;
         end
         S_WON, S_WON_WAIT: begin
            game_won_d  = 1'b1;
            game_over_d = 1'b1;
         end
         S_LOST, S_LOST_WAIT: begin
            game_over_d = 1'b1;
         end
         default: begin
            load_code_d = PEG_ZERO;
         end
      endcase
   end

   // State, slot, counter and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_LOAD_CODE;
         slot_q        <= SLOT_ZERO;
         guess_count_q <= CNT_ZERO;
         load_code_q   <= PEG_ONE;
         load_guess_q  <= PEG_ZERO;
         compare_q     <= 1'b0;
         compare_i_q   <= SLOT_ZERO;
         result_done_q <= 1'b0;
         game_won_q    <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_q        <= slot_d;
         guess_count_q <= guess_count_d;
         load_code_q   <= load_code_d;
         load_guess_q  <= load_guess_d;
         compare_q     <= compare_d;
         compare_i_q   <= compare_i_d;
         result_done_q <= result_done_d;
         game_won_q    <= game_won_d;
         game_over_q   <= game_over_d;
      end
   end

   assign load_code   = load_code_q;
   assign load_guess  = load_guess_q;
   assign compare     = compare_q;
   assign compare_i   = compare_i_q;
   assign result_done = result_done_q;
   assign guess_count = guess_count_q;
   assign game_won    = game_won_q;
   assign game_over   = game_over_q;

endmodule

// File: doc/mm_round_ctrl.md
Name: mm_round_ctrl

Overview:
Parametrised Mastermind round controller. It sequences secret-code entry, guess entry, per-peg comparison and end-of-game detection for N_PEGS pegs. It drives the code/guess register file and the peg comparator datapath from a single debounced "load" button. It also tracks the guess count and declares win or loss.

Parameters:
N_PEGS, 4, pegs per code/guess (2..16)
IDX_W, 2, width of peg index; must satisfy 2**IDX_W >= N_PEGS
MAX_GUESSES, 10, guesses allowed before loss (1..2**CNT_W-1)
CNT_W, 4, width of guess counter

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
load  in  1  debounced load button, level, active-high
all_exact  in  1  from datapath: every peg exact-matched, valid in RESULT_DONE
load_code  out  N_PEGS  one-hot write enable for code slot
load_guess  out  N_PEGS  one-hot write enable for guess slot
compare  out  1  comparator enable
compare_i  out  IDX_W  peg index being compared
result_done  out  1  one-cycle pulse: comparison of current guess finished
guess_count  out  CNT_W  guesses fully compared this game
game_won  out  1  level, game ended with correct guess
game_over  out  1  level, game ended (won or lost)

Behaviour:
- Single Moore FSM plus slot index `slot` (IDX_W) and `guess_count` (CNT_W). Outputs decode from registered state only.
- Asynchronous reset while resetn=0: state=LOAD_CODE, slot=0, guess_count=0. Takes effect immediately, including mid-operation.
- Reset output values: load_code=1 (bit 0 only); all other outputs 0.
- States and transitions:
  - LOAD_CODE: load=1 -> LOAD_CODE_WAIT, else stay.
  - LOAD_CODE_WAIT: load=1 stay. On load=0: if slot==N_PEGS-1 -> GUESS with slot=0; else slot+1 -> LOAD_CODE.
  - GUESS / GUESS_WAIT: same press-release rule as code entry. Last slot's release -> COMPARE with slot=0.
  - COMPARE: one cycle per peg, compare=1, compare_i=slot. slot increments each cycle. At slot==N_PEGS-1 -> RESULT_DONE, slot=0.
  - RESULT_DONE: one cycle, result_done=1, guess_count increments.
    - all_exact=1 -> WON.
    - else if incremented count == MAX_GUESSES -> LOST.
    - else -> GUESS.
  - WON: game_won=1, game_over=1. LOST: game_over=1. Both ignore load unless the optional feature is enabled.
- load_code[slot]=1 only in LOAD_CODE; load_guess[slot]=1 only in GUESS. Both are all-zero in every WAIT state.
- A write enable is held for the whole time the button is up; the datapath captures every cycle. The value latched at the press cycle is final.
- A held load never advances more than one slot. A new slot is entered only after release, then a fresh press.
- Comparison latency: N_PEGS cycles after last-slot release, then RESULT_DONE.
- load is ignored during COMPARE and RESULT_DONE. A release occurring then does not count.
- guess_count saturates at MAX_GUESSES, never wraps.
- all_exact is sampled only in RESULT_DONE.
- Illegal state encoding -> LOAD_CODE, slot=0.

Optional Feature:
MM_RESTART_EN
- Defined: in WON or LOST, a load press then release returns to LOAD_CODE. On that release, slot=0 and guess_count=0; game_won and game_over drop on the return.
- Undefined: WON/LOST are terminal until resetn is asserted.

Test Plan:
1. N_PEGS=4: reset, then 4 press/release pairs -> load_code one-hot steps 0001, 0010, 0100, 1000. Then enters GUESS with load_guess=0001.
2. Hold load high 20 cycles in GUESS slot 1 -> load_guess=0000 for the whole hold. Only slot 1 advances to slot 2 on release.
3. After the 4th guess release -> compare=1 with compare_i 0,1,2,3 on consecutive cycles. Then result_done pulses one cycle and guess_count=1.
4. all_exact=1 in RESULT_DONE -> game_won=1, game_over=1. Further load toggles are ignored (macro undefined).
5. MAX_GUESSES=3 with all_exact=0 always -> after the 3rd result_done, game_over=1, game_won=0, guess_count=3.
6. resetn pulsed low during COMPARE at compare_i=2 -> outputs go to reset values immediately. With MM_RESTART_EN defined, a press/release in LOST -> load_code=0001 and guess_count=0.
